// File: rtl/sipo_deser_if.sv
// sipo_deser_if: serial receive bus for the sipo_deser deserializer.
//   master modport : the side that drives serial bits, strobes, the consumer
//                    ready and error clear, and observes the word port/flags.
//   slave modport  : the deserializer itself.
// Signals:
//   sin, sin_en, sync    serial bit, bit strobe, word-start marker
//   dout, dout_valid     assembled word and its valid flag
//   dout_ready           consumer accept
//   overrun, frame_err   sticky error flags
//   err_clr              synchronous clear of both sticky flags
// Handshake: a word transfers on a rising edge where dout_valid=1 and
// dout_ready=1. dout_valid stays high and dout stays stable until that edge;
// dout_ready has no effect while dout_valid=0.
interface sipo_deser_if #(
    parameter int WIDTH = 4
);
    logic             sin;
    logic             sin_en;
    logic             sync;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             overrun;
    logic             frame_err;
    logic             err_clr;

    modport master (
        output sin, sin_en, sync, dout_ready, err_clr,
        input  dout, dout_valid, overrun, frame_err
    );

    modport slave (
        input  sin, sin_en, sync, dout_ready, err_clr,
        output dout, dout_valid, overrun, frame_err
    );
endinterface

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in, parallel-out deserializer for the receive side of
// the serial link. Reassembles LSB-first WIDTH-bit words framed by a sync
// strobe and presents them on a valid/ready word port.
// Ports:
//   clk        rising-edge clock
//   clr_n      asynchronous active-low reset
//   bus        sipo_deser_if.slave (serial input, word output, flags)
//   state_dbg  receiver state: 0 = HUNT (waiting for sync), 1 = RECV
// Parameters:
//   WIDTH   word width (>= 2)
//   RESYNC  0: words follow back to back after the first sync;
//           1: every word needs its own sync
module sipo_deser #(
    parameter int WIDTH  = 4,
    parameter bit RESYNC = 1'b0
) (
    input  logic        clk,
    input  logic        clr_n,
    sipo_deser_if.slave bus,
    output logic        state_dbg
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic             word_done;
    logic             frame_evt;
    logic             ovr_evt;
    logic [WIDTH-1:0] shifted;

    // Incoming bit enters at the top so the first bit received ends in bit 0.
    assign shifted = {bus.sin, sr_q[WIDTH-1:1]};

    // State register (plus datapath registers).
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= HUNT;
            cnt_q   <= '0;
            sr_q    <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state logic: framing, bit counting and shifting.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        word_done = 1'b0;
        frame_evt = 1'b0;
        if (bus.sin_en) begin
            case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        sr_d    = shifted;
                        cnt_d   = ONE;
                        state_d = RECV;
                    end
                end
                RECV: begin
                    sr_d = shifted;
                    if (bus.sync) begin
                        // Sync restarts the word; it beats completion if
                        // both would happen on the same bit.
                        frame_evt = (cnt_q != '0);
                        cnt_d     = ONE;
                    end else if (cnt_q == LAST) begin
                        word_done = 1'b1;
                        cnt_d     = '0;
                        if (RESYNC) begin
                            state_d = HUNT;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // Output logic: word register, valid flag and sticky errors.
    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        ovr_evt = 1'b0;
        if (word_done) begin
            // A handshake on the same edge frees the slot for the new word.
            if (!valid_q || bus.dout_ready) begin
                dout_d  = shifted;
                valid_d = 1'b1;
            end else begin
                ovr_evt = 1'b1;
            end
        end else if (valid_q && bus.dout_ready) begin
            valid_d = 1'b0;
        end
        // A new error event on the clear edge wins over the clear.
        ovr_d  = ovr_evt   | (ovr_q  & ~bus.err_clr);
        ferr_d = frame_evt | (ferr_q & ~bus.err_clr);
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.overrun    = ovr_q;
    assign bus.frame_err  = ferr_q;
    assign state_dbg      = (state_q == RECV);

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: two instances (RESYNC=0 and RESYNC=1) share one
// stimulus stream. A word-level reference model predicts each delivered word
// and the flags; delivered words are queued with their expected cycle and a
// separate monitor pops them when a DUT presents a new word.
module tb_sipo_deser;

    localparam int W = 4;

    logic clk;
    logic clr_n;
    logic sin, sin_en, sync, dout_ready, err_clr;
    logic state_dbg0, state_dbg1;

    sipo_deser_if #(.WIDTH(W)) bus0 ();
    sipo_deser_if #(.WIDTH(W)) bus1 ();

    assign bus0.sin = sin;         assign bus1.sin = sin;
    assign bus0.sin_en = sin_en;   assign bus1.sin_en = sin_en;
    assign bus0.sync = sync;       assign bus1.sync = sync;
    assign bus0.dout_ready = dout_ready;  assign bus1.dout_ready = dout_ready;
    assign bus0.err_clr = err_clr; assign bus1.err_clr = err_clr;

    sipo_deser #(.WIDTH(W), .RESYNC(1'b0)) u_dut0 (
        .clk(clk), .clr_n(clr_n), .bus(bus0.slave), .state_dbg(state_dbg0)
    );
    sipo_deser #(.WIDTH(W), .RESYNC(1'b1)) u_dut1 (
        .clk(clk), .clr_n(clr_n), .bus(bus1.slave), .state_dbg(state_dbg1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model state ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    logic           m_in[2];      // inside a framed stream (RECV)
    int             m_n[2];       // bits collected for current word
    logic [W-1:0]   m_acc[2];     // bits collected, placed by position
    logic           m_valid[2];
    logic [W-1:0]   m_dout[2];
    logic           m_ovr[2];
    logic           m_ferr[2];
    logic [W-1:0]   exp_q0[$], exp_q1[$];
    int             exp_c0[$], exp_c1[$];

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_in[k] = 1'b0; m_n[k] = 0; m_acc[k] = '0;
            m_valid[k] = 1'b0; m_dout[k] = '0; m_ovr[k] = 1'b0; m_ferr[k] = 1'b0;
        end
        exp_q0.delete(); exp_q1.delete(); exp_c0.delete(); exp_c1.delete();
    endtask

    task automatic model_edge(input logic b, input logic en, input logic sy,
                              input logic rdy, input logic ec);
        for (int k = 0; k < 2; k++) begin
            logic         done;
            logic         ovr_evt;
            logic         ferr_evt;
            logic         hs;
            logic [W-1:0] word;
            done = 1'b0; ovr_evt = 1'b0; ferr_evt = 1'b0; word = '0;
            hs = m_valid[k] && rdy;
            if (en) begin
                if (sy) begin
                    if (m_in[k] && m_n[k] != 0) ferr_evt = 1'b1;
                    m_acc[k] = '0;
                    m_acc[k][0] = b;
                    m_n[k] = 1;
                    m_in[k] = 1'b1;
                end else if (m_in[k]) begin
                    m_acc[k][m_n[k]] = b;
                    m_n[k]++;
                    if (m_n[k] == W) begin
                        word = m_acc[k];
                        done = 1'b1;
                        m_n[k] = 0;
                        m_acc[k] = '0;
                        if (k == 1) m_in[k] = 1'b0;
                    end
                end
            end
            if (done) begin
                if (!m_valid[k] || rdy) begin
                    m_dout[k] = word;
                    m_valid[k] = 1'b1;
                    if (k == 0) begin exp_q0.push_back(word); exp_c0.push_back(cyc); end
                    else        begin exp_q1.push_back(word); exp_c1.push_back(cyc); end
                end else begin
                    ovr_evt = 1'b1;
                end
            end else if (hs) begin
                m_valid[k] = 1'b0;
            end
            m_ovr[k]  = ovr_evt  ? 1'b1 : (ec ? 1'b0 : m_ovr[k]);
            m_ferr[k] = ferr_evt ? 1'b1 : (ec ? 1'b0 : m_ferr[k]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic b, input logic en, input logic sy,
                        input logic rdy, input logic ec);
        sin = b; sin_en = en; sync = sy; dout_ready = rdy; err_clr = ec;
        @(posedge clk);
        cyc++;
        model_edge(b, en, sy, rdy, ec);
        #1;
    endtask

    task automatic send_bits(input logic [W-1:0] w, input logic sync_first,
                             input logic gap, input logic rdy);
        for (int i = 0; i < W; i++) begin
            step(w[i], 1'b1, sync_first && (i == 0), rdy, 1'b0);
            if (gap) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), rdy, 1'b0);
        end
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        #3;
        clr_n = 1'b0;
        model_clear();
        @(posedge clk);
        cyc++;
        #1;
        clr_n = 1'b1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic pv[2];
    logic phs[2];

    task automatic mon(input int k, input logic [W-1:0] d, input logic v,
                       input logic o, input logic f, input logic s);
        if (!clr_n) begin
            check("reset_dout", k, 32'(d), 0);
            check("reset_valid", k, 32'(v), 0);
            check("reset_overrun", k, 32'(o), 0);
            check("reset_frame_err", k, 32'(f), 0);
            check("reset_state", k, 32'(s), 0);
            pv[k] = 1'b0; phs[k] = 1'b0;
            return;
        end
        check("valid", k, 32'(v), 32'(m_valid[k]));
        check("overrun", k, 32'(o), 32'(m_ovr[k]));
        check("frame_err", k, 32'(f), 32'(m_ferr[k]));
        check("state", k, 32'(s), 32'(m_in[k]));
        if (v) check("dout", k, 32'(d), 32'(m_dout[k]));
        if (v && (!pv[k] || phs[k])) begin
            logic [W-1:0] ew;
            int           ec;
            if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                check("unexpected_word", k, 32'(d), 32'hffff_ffff);
            end else begin
                if (k == 0) begin ew = exp_q0.pop_front(); ec = exp_c0.pop_front(); end
                else        begin ew = exp_q1.pop_front(); ec = exp_c1.pop_front(); end
                check("word", k, 32'(d), 32'(ew));
                check("word_cycle", k, 32'(cyc), 32'(ec));
            end
        end
        pv[k]  = v;
        phs[k] = v && dout_ready;
    endtask

    initial begin
        pv[0] = 1'b0; pv[1] = 1'b0; phs[0] = 1'b0; phs[1] = 1'b0;
        forever begin
            @(negedge clk);
            mon(0, bus0.dout, bus0.dout_valid, bus0.overrun, bus0.frame_err, state_dbg0);
            mon(1, bus1.dout, bus1.dout_valid, bus1.overrun, bus1.frame_err, state_dbg1);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        clr_n = 1'b0;
        sin = 1'b0; sin_en = 1'b0; sync = 1'b0; dout_ready = 1'b0; err_clr = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        clr_n = 1'b1;

        // Continuous stream: 4'b1101 framed, then 4'b0010 without sync.
        send_bits(4'b1101, 1'b1, 1'b0, 1'b1);
        send_bits(4'b0010, 1'b0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Gapped strobe.
        send_bits(4'b1101, 1'b1, 1'b1, 1'b1);
        idle(3, 1'b1);

        // Backpressure: second word dropped, then drain and clear.
        send_bits(4'hA, 1'b1, 1'b0, 1'b0);
        send_bits(4'h5, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Mid-word sync.
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send_bits(4'hE, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Resync behaviour: unsynced bits after 4'h3.
        send_bits(4'h3, 1'b1, 1'b0, 1'b1);
        send_bits(4'h6, 1'b0, 1'b0, 1'b1);
        idle(2, 1'b1);
        send_bits(4'h9, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Reset mid-word with a held word pending.
        send_bits(4'h7, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        send_bits(4'h9, 1'b1, 1'b0, 1'b1);
        idle(2, 1'b1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 6) == 0),
                 1'($urandom_range(0, 9) < 7),
                 1'($urandom_range(0, 19) == 0));
        end

        // Drain and confirm every predicted word was seen.
        idle(6, 1'b1);
        check("drain_q", 0, 32'(exp_q0.size()), 0);
        check("drain_q", 1, 32'(exp_q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
# sipo_deser

Serial-in, parallel-out deserializer for the receive side of the 4-bit serial link. It consumes the LSB-first bit stream produced by the parallel-in/serial-out transmit stage and reassembles WIDTH-bit words. It frames words using a sync strobe and presents each word on a valid/ready output port. Sticky overrun and framing-error flags are provided for the consuming logic.

## Interface
- WIDTH, 4: word width in bits; must be ≥ 2.
- RESYNC, 0: 0 = after a word completes, the next accepted bit is bit 0 of the next word; 1 = after each word, return to HUNT and wait for a new sync.
- clk  input  1  rising-edge clock.
- clr_n  input  1  reset; one clock; reset is asynchronous and active-low.
- sin  input  1  serial data bit.
- sin_en  input  1  bit strobe; sin is accepted only on edges where sin_en=1.
- sync  input  1  qualified by sin_en; marks the accepted bit as bit 0 of a word.
- dout  output  WIDTH  assembled word; bit 0 is the first bit received.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts; a transfer occurs on an edge with dout_valid=1 and dout_ready=1.
- overrun  output  1  sticky; a completed word was dropped.
- frame_err  output  1  sticky; sync arrived mid-word.
- err_clr  input  1  synchronous clear of overrun and frame_err.

## Operation
- Reset (clr_n=0, asynchronous) forces: state HUNT, bit counter 0, shift register 0, dout 0, dout_valid 0, overrun 0, frame_err 0. Release takes effect on the first rising edge with clr_n=1.
- Shift rule on each accepted bit: sr <= {sin, sr[WIDTH-1:1]}. This is LSB-first, so after WIDTH bits, sr[0] is the first bit received.
- The counter is $clog2(WIDTH) bits wide and counts accepted bits of the current word (0..WIDTH-1).
- HUNT:
  - Accepted bits without sync are ignored.
  - sin_en=1 with sync=1: shift the bit in, set cnt=1, go to RECV.
- RECV:
  - Each accepted bit shifts in and increments cnt.
  - On the bit that completes the word (cnt==WIDTH-1 before the edge), the word {sin, sr[WIDTH-1:1]} is the completed word. Then cnt=0, and the state returns to HUNT if RESYNC=1, else stays in RECV.
  - sync=1 on an accepted bit with cnt≠0: discard the partial word, set frame_err, shift the bit in as bit 0, set cnt=1, stay in RECV. If WIDTH would complete at that bit, sync takes priority and the word is not completed.
  - sync=1 with cnt==0 in RECV is a normal word start and is not an error.
- Output register:
  - Word complete with dout_valid=0: load dout, set dout_valid=1.
  - Word complete with dout_valid=1 and dout_ready=1 on the same edge: load the new word into dout; dout_valid stays 1.
  - Word complete with dout_valid=1 and dout_ready=0: drop the new word, keep dout unchanged, set overrun.
  - Handshake with no word completing: dout_valid <= 0; dout holds its last value.
- err_clr=1 clears both sticky flags. If a new error event occurs on the same edge, the set wins.
- dout_ready while dout_valid=0 has no effect.

## Timing
- Latency: the completed word appears on dout with dout_valid=1 immediately after the edge that accepts the final bit, i.e. 1 cycle after that bit is presented.
- Throughput: one bit per cycle with sin_en tied high. With RESYNC=0, one word per WIDTH cycles and no bubble between words.
- dout_valid, once set, stays high until a handshake edge; dout is stable while dout_valid=1.
- overrun and frame_err assert on the edge after the causing event.
- All outputs are registered; there is no combinational path from any input to any output.
- Reset asserted mid-word or with dout_valid=1 discards everything immediately, with no handshake.

## Test plan
- Continuous 4-bit stream, RESYNC=0, sin_en=1, dout_ready=1: sync on first bit, then bits 1,0,1,1 followed by 0,1,0,0 -> dout=4'b1101 the cycle after bit 4, then 4'b0010 four cycles later; dout_valid high both times; no flags.
- Gapped strobe: same word 4'b1101 sent with sin_en toggling 1,0,1,0,… -> dout=4'b1101 exactly one cycle after the 4th accepted bit; bits presented with sin_en=0 are ignored.
- Backpressure: dout_ready=0, two words 4'hA then 4'h5 -> dout stays 4'hA and overrun=1 after the second word. Raise dout_ready for one cycle -> dout_valid=0. Assert err_clr -> overrun=0.
- Mid-word sync: two bits accepted, then sync with bits 0,1,1,1 -> frame_err=1, dout=4'hE; the partial word is never output.
- RESYNC=1: word 4'h3 received, then 4 bits without sync -> no second word, state stays in HUNT; a new sync then starts reception normally.
- Reset mid-operation: clr_n pulsed low asynchronously after 2 bits, with a held word pending -> dout=0, dout_valid=0, flags 0 immediately; the next sync-framed word 4'h9 is received correctly.
